uart_msg_gen: RTL



---
 rtl/uart_msg_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_msg_gen.sv
// Streams the fixed message "Hello Nexys A7\r\n" to a UART transmitter over valid/ready,
// either once per start pulse or repeatedly with an idle gap between messages.
module uart_msg_gen #(
  parameter int unsigned GAP_CYCLES  = 100_000_000,
  parameter bit          AUTO_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam state_e RST_STATE = AUTO_REPEAT ? SEND : IDLE;
  localparam logic [3:0] LAST_IDX = 4'd15;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    msg_byte = 8'h48;
      4'd1:    msg_byte = 8'h65;
      4'd2:    msg_byte = 8'h6C;
      4'd3:    msg_byte = 8'h6C;
      4'd4:    msg_byte = 8'h6F;
      4'd5:    msg_byte = 8'h20;
      4'd6:    msg_byte = 8'h4E;
      4'd7:    msg_byte = 8'h65;
      4'd8:    msg_byte = 8'h78;
      4'd9:    msg_byte = 8'h79;
      4'd10:   msg_byte = 8'h73;
      4'd11:   msg_byte = 8'h20;
      4'd12:   msg_byte = 8'h41;
      4'd13:   msg_byte = 8'h37;
      4'd14:   msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          xfer;

  assign xfer = valid_q & tx_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = AUTO_REPEAT ? GAP : IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the byte for index i+1 appears
    // at the same edge that accepts byte i.
    valid_d = (state_d == SEND);
    data_d  = valid_d ? msg_byte(idx_d) : 8'h00;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // busy tracks the registered valid so it reads low in the first auto-mode cycle after reset.
  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign busy     = valid_q;
  assign done     = done_q;

endmodule
